// File: rtl/weight_pingpong_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | weight_pingpong_buffer_pkg                                           |
// | Shared bank state type and parameter defaults for the weight buffer. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package weight_pingpong_buffer_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2
   } bank_state_t;

   localparam int c_default_num_banks = 2;
   localparam int c_default_lanes     = 4;
   localparam int c_default_data_w    = 8;
   localparam int c_default_depth     = 256;

endpackage
`default_nettype wire

// File: rtl/weight_bank_sram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | weight_bank_sram                                                     |
// | 1R1W bank storage: synchronous write, registered one-cycle read.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module weight_bank_sram
   import weight_pingpong_buffer_pkg::*;
#(
   parameter int WIDTH  = c_default_lanes * c_default_data_w,
   parameter int DEPTH  = c_default_depth,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_data;

   // The array itself is never reset so it maps onto plain memory macros.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_data <= '0;
      end else if (rd_en) begin
         r_rd_data <= r_mem[rd_addr];
      end
   end

   assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/weight_pingpong_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | weight_pingpong_buffer                                               |
// | Round-robin multi-bank weight buffer: one bank fills while another   |
// | is read, with per-bank EMPTY/FILLING/FULL tracking.                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module weight_pingpong_buffer
   import weight_pingpong_buffer_pkg::*;
#(
   parameter int NUM_BANKS = c_default_num_banks,
   parameter int LANES     = c_default_lanes,
   parameter int DATA_W    = c_default_data_w,
   parameter int DEPTH     = c_default_depth,
   parameter int ADDR_W    = $clog2(DEPTH),
   parameter int BANK_W    = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [ADDR_W-1:0]         wr_addr,
   input  logic [LANES*DATA_W-1:0]   wr_data,
   input  logic                      wr_last,
   input  logic                      rd_en,
   input  logic [ADDR_W-1:0]         rd_addr,
   output logic [LANES*DATA_W-1:0]   rd_data,
   output logic                      rd_valid,
   input  logic                      rd_release,
   output logic                      bank_ready,
   output logic [BANK_W-1:0]         wr_bank,
   output logic [BANK_W-1:0]         rd_bank,
   output logic [BANK_W:0]           full_count,
   output logic                      overflow_err,
   output logic                      underflow_err
);

   localparam int WORD_W = LANES * DATA_W;
   localparam logic [BANK_W-1:0] c_last_bank = BANK_W'(NUM_BANKS - 1);

   bank_state_t        r_state [NUM_BANKS];
   logic [BANK_W-1:0]  r_wr_bank;
   logic [BANK_W-1:0]  r_rd_bank;
   logic [BANK_W-1:0]  r_rd_sel;
   logic               r_rd_valid;
   logic               r_overflow;
   logic               r_underflow;

   logic               w_wr_ready;
   logic               w_bank_ready;
   logic               w_wr_accept;
   logic               w_rd_accept;
   logic               w_release;
   logic [BANK_W-1:0]  w_wr_bank_next;
   logic [BANK_W-1:0]  w_rd_bank_next;
   logic [BANK_W:0]    w_full_count;
   logic [WORD_W-1:0]  w_bank_rdata [NUM_BANKS];

   assign w_wr_ready   = (r_state[r_wr_bank] != FULL);
   assign w_bank_ready = (r_state[r_rd_bank] == FULL);

   // clear overrides every request, including error reporting.
   assign w_wr_accept  = wr_valid   & w_wr_ready   & ~clear;
   assign w_rd_accept  = rd_en      & w_bank_ready & ~clear;
   assign w_release    = rd_release & w_bank_ready & ~clear;

   assign w_wr_bank_next = (r_wr_bank == c_last_bank) ? '0 : r_wr_bank + 1'b1;
   assign w_rd_bank_next = (r_rd_bank == c_last_bank) ? '0 : r_rd_bank + 1'b1;

   always_comb begin
      w_full_count = '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         if (r_state[i] == FULL) begin
            w_full_count = w_full_count + (BANK_W + 1)'(1);
         end
      end
   end

   // A released bank is always FULL and the fill bank never is, so the two
   // state updates below can never target the same bank in one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            r_state[i] <= EMPTY;
         end
         r_wr_bank   <= '0;
         r_rd_bank   <= '0;
         r_rd_sel    <= '0;
         r_rd_valid  <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (clear) begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            r_state[i] <= EMPTY;
         end
         r_wr_bank  <= '0;
         r_rd_bank  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_accept;
         if (w_rd_accept) begin
            r_rd_sel <= r_rd_bank;
         end
         if ((rd_en | rd_release) & ~w_bank_ready) begin
            r_underflow <= 1'b1;
         end
         if (wr_valid & ~w_wr_ready) begin
            r_overflow <= 1'b1;
         end
         if (w_release) begin
            r_state[r_rd_bank] <= EMPTY;
            r_rd_bank          <= w_rd_bank_next;
         end
         if (w_wr_accept) begin
            r_state[r_wr_bank] <= wr_last ? FULL : FILLING;
            if (wr_last) begin
               r_wr_bank <= w_wr_bank_next;
            end
         end
      end
   end

   generate
      for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
         weight_bank_sram #(
            .WIDTH  (WORD_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
         ) u_sram (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (w_wr_accept && (r_wr_bank == BANK_W'(g))),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_en   (w_rd_accept && (r_rd_bank == BANK_W'(g))),
            .rd_addr (rd_addr),
            .rd_data (w_bank_rdata[g])
         );
      end
   endgenerate

   // r_rd_sel only moves on an accepted read, so rd_data holds between reads.
   assign rd_data       = w_bank_rdata[r_rd_sel];
   assign rd_valid      = r_rd_valid;
   assign wr_ready      = w_wr_ready;
   assign bank_ready    = w_bank_ready;
   assign wr_bank       = r_wr_bank;
   assign rd_bank       = r_rd_bank;
   assign full_count    = w_full_count;
   assign overflow_err  = r_overflow;
   assign underflow_err = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_weight_pingpong_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_weight_pingpong_buffer                                            |
// | Two-bank and four-bank instances driven in lockstep against a model. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_weight_pingpong_buffer;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int W     = 32;
   localparam int NBS [2] = '{2, 4};

   logic          clk = 1'b0;
   logic          reset, clear, wr_valid, wr_last, rd_en, rd_release;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [W-1:0]  wr_data;

   logic          wr_ready_a, rd_valid_a, bank_ready_a, overflow_a, underflow_a;
   logic [W-1:0]  rd_data_a;
   logic [0:0]    wr_bank_a, rd_bank_a;
   logic [1:0]    full_count_a;
   logic          wr_ready_b, rd_valid_b, bank_ready_b, overflow_b, underflow_b;
   logic [W-1:0]  rd_data_b;
   logic [1:0]    wr_bank_b, rd_bank_b;
   logic [2:0]    full_count_b;

   weight_pingpong_buffer #(.NUM_BANKS(2), .LANES(4), .DATA_W(8), .DEPTH(DEPTH)) dut_a (
      .clk(clk), .reset(reset), .clear(clear),
      .wr_valid(wr_valid), .wr_ready(wr_ready_a), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_last(wr_last), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
      .rd_valid(rd_valid_a), .rd_release(rd_release), .bank_ready(bank_ready_a),
      .wr_bank(wr_bank_a), .rd_bank(rd_bank_a), .full_count(full_count_a),
      .overflow_err(overflow_a), .underflow_err(underflow_a));

   weight_pingpong_buffer #(.NUM_BANKS(4), .LANES(4), .DATA_W(8), .DEPTH(DEPTH)) dut_b (
      .clk(clk), .reset(reset), .clear(clear),
      .wr_valid(wr_valid), .wr_ready(wr_ready_b), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_last(wr_last), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
      .rd_valid(rd_valid_b), .rd_release(rd_release), .bank_ready(bank_ready_b),
      .wr_bank(wr_bank_b), .rd_bank(rd_bank_b), .full_count(full_count_b),
      .overflow_err(overflow_b), .underflow_err(underflow_b));

   always #5 clk = ~clk;

   // Reference model: 0 = empty, 1 = filling, 2 = full
   int           m_state [2][4];
   logic [W-1:0] m_mem   [2][4][DEPTH];
   int           m_wb [2], m_rb [2];
   logic         m_rv [2], m_ovf [2], m_unf [2];
   logic [W-1:0] m_rd [2];

   int passed = 0;
   int failed = 0;
   int total  = 0;

   task automatic model_reset(input int m);
      for (int b = 0; b < 4; b++) m_state[m][b] = 0;
      m_wb[m] = 0; m_rb[m] = 0; m_rv[m] = 1'b0; m_rd[m] = '0;
      m_ovf[m] = 1'b0; m_unf[m] = 1'b0;
   endtask

   task automatic model_step(input int m);
      bit wr_ok, br;
      if (clear) begin
         for (int b = 0; b < 4; b++) m_state[m][b] = 0;
         m_wb[m] = 0; m_rb[m] = 0; m_rv[m] = 1'b0;
         return;
      end
      wr_ok = (m_state[m][m_wb[m]] != 2);
      br    = (m_state[m][m_rb[m]] == 2);
      m_rv[m] = 1'b0;
      if (rd_en) begin
         if (br) begin
            m_rd[m] = m_mem[m][m_rb[m]][rd_addr];
            m_rv[m] = 1'b1;
         end else m_unf[m] = 1'b1;
      end
      if (rd_release) begin
         if (br) begin
            m_state[m][m_rb[m]] = 0;
            m_rb[m] = (m_rb[m] + 1) % NBS[m];
         end else m_unf[m] = 1'b1;
      end
      if (wr_valid) begin
         if (wr_ok) begin
            m_mem[m][m_wb[m]][wr_addr] = wr_data;
            if (wr_last) begin
               m_state[m][m_wb[m]] = 2;
               m_wb[m] = (m_wb[m] + 1) % NBS[m];
            end else m_state[m][m_wb[m]] = 1;
         end else m_ovf[m] = 1'b1;
      end
   endtask

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_dut(input int m, input string tag, input logic wrr, input logic br,
                          input logic [W-1:0] wb, input logic [W-1:0] rb, input logic [W-1:0] fc,
                          input logic ov, input logic un, input logic rv, input logic [W-1:0] rd);
      string p;
      int    nfull = 0;
      p = $sformatf("%s nb%0d", tag, NBS[m]);
      for (int b = 0; b < NBS[m]; b++) if (m_state[m][b] == 2) nfull++;
      chk({p, " wr_ready"},      W'(wrr), W'(m_state[m][m_wb[m]] != 2));
      chk({p, " bank_ready"},    W'(br),  W'(m_state[m][m_rb[m]] == 2));
      chk({p, " wr_bank"},       wb,      W'(m_wb[m]));
      chk({p, " rd_bank"},       rb,      W'(m_rb[m]));
      chk({p, " full_count"},    fc,      W'(nfull));
      chk({p, " overflow_err"},  W'(ov),  W'(m_ovf[m]));
      chk({p, " underflow_err"}, W'(un),  W'(m_unf[m]));
      chk({p, " rd_valid"},      W'(rv),  W'(m_rv[m]));
      chk({p, " rd_data"},       rd,      m_rd[m]);
   endtask

   task automatic check_all(input string tag);
      chk_dut(0, tag, wr_ready_a, bank_ready_a, W'(wr_bank_a), W'(rd_bank_a), W'(full_count_a),
              overflow_a, underflow_a, rd_valid_a, rd_data_a);
      chk_dut(1, tag, wr_ready_b, bank_ready_b, W'(wr_bank_b), W'(rd_bank_b), W'(full_count_b),
              overflow_b, underflow_b, rd_valid_b, rd_data_b);
   endtask

   task automatic set_in(input logic wv, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                         input logic wl, input logic re, input logic [AW-1:0] ra,
                         input logic rr, input logic cl);
      wr_valid = wv; wr_addr = wa; wr_data = wd; wr_last = wl;
      rd_en = re; rd_addr = ra; rd_release = rr; clear = cl;
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check_all(tag);
      set_in(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   // Called just after a step: asserts reset between clock edges.
   task automatic pulse_reset(input string tag);
      #1 reset = 1'b1;
      model_reset(0);
      model_reset(1);
      #1;
      check_all(tag);
      reset = 1'b0;
   endtask

   initial begin
      set_in(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      reset = 1'b1;
      model_reset(0);
      model_reset(1);
      #2;
      check_all("reset");
      chk("reset wr_ready nb2", W'(wr_ready_a), 32'd1);
      chk("reset rd_data nb4", rd_data_b, 32'd0);
      @(negedge clk) reset = 1'b0;

      // Preload every word of every bank; four layers wrap both pointers.
      for (int l = 0; l < 4; l++) begin
         for (int a = 0; a < DEPTH; a++) begin
            if (l == 3 && a == 0) chk("wrap pre wr_bank nb4", W'(wr_bank_b), 32'd3);
            set_in(1'b1, AW'(a), $urandom, a == DEPTH - 1, 1'b0, '0, 1'b0, 1'b0);
            step("preload");
         end
         if (l == 3) chk("wrap pre rd_bank nb4", W'(rd_bank_b), 32'd3);
         set_in(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
         step("release");
      end
      chk("wrap wr_bank nb4", W'(wr_bank_b), 32'd0);
      chk("wrap rd_bank nb4", W'(rd_bank_b), 32'd0);
      pulse_reset("reset after preload");

      // Fill bank0 and read word 2 back
      for (int a = 0; a < 4; a++) begin
         set_in(1'b1, AW'(a), 32'h01020304 + a * 32'h10101010, a == 3, 1'b0, '0, 1'b0, 1'b0);
         step("fill0");
      end
      chk("fill0 bank_ready", W'(bank_ready_a), 32'd1);
      chk("fill0 wr_bank", W'(wr_bank_a), 32'd1);
      chk("fill0 full_count", W'(full_count_a), 32'd1);
      set_in(1'b0, '0, '0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
      step("read2");
      chk("read2 rd_valid", W'(rd_valid_a), 32'd1);
      chk("read2 rd_data", rd_data_a, 32'h21222324);
      step("idle hold");

      // Both banks full on nb2: next write is dropped
      set_in(1'b1, 4'd0, 32'h5555AAAA, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      step("fill1");
      chk("both full wr_ready", W'(wr_ready_a), 32'd0);
      set_in(1'b1, 4'd1, 32'hDEADDEAD, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      step("drop");
      chk("drop overflow_err", W'(overflow_a), 32'd1);
      chk("drop full_count", W'(full_count_a), 32'd2);
      set_in(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      step("release0");
      chk("release0 wr_ready", W'(wr_ready_a), 32'd1);

      // Read from an empty buffer after reset
      pulse_reset("reset underflow");
      set_in(1'b0, '0, '0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      step("underflow");
      chk("underflow rd_valid", W'(rd_valid_a), 32'd0);
      chk("underflow flag", W'(underflow_a), 32'd1);
      chk("underflow rd_bank", W'(rd_bank_a), 32'd0);

      // Concurrent wr_last into bank1 and release of bank0
      set_in(1'b1, 4'd0, 32'h0BADF00D, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      step("fill0 again");
      set_in(1'b1, 4'd5, 32'hCAFEBABE, 1'b1, 1'b0, '0, 1'b1, 1'b0);
      step("concurrent");
      chk("concurrent full_count", W'(full_count_a), 32'd1);
      chk("concurrent rd_bank", W'(rd_bank_a), 32'd1);
      chk("concurrent wr_bank", W'(wr_bank_a), 32'd0);
      chk("concurrent bank_ready", W'(bank_ready_a), 32'd1);

      // Read and release together
      set_in(1'b0, '0, '0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0);
      step("read+release");
      chk("read+release rd_data", rd_data_a, 32'hCAFEBABE);
      chk("read+release rd_valid", W'(rd_valid_a), 32'd1);
      chk("read+release full_count", W'(full_count_a), 32'd0);

      // clear wins over simultaneous requests and keeps error flags
      set_in(1'b1, 4'd3, 32'h12345678, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      step("pre clear");
      set_in(1'b1, 4'd4, 32'h87654321, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1);
      step("clear");
      chk("clear full_count", W'(full_count_b), 32'd0);
      chk("clear underflow kept", W'(underflow_a), 32'd1);

      // Reset in the middle of a fill
      set_in(1'b1, 4'd7, 32'h77777777, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      step("mid fill");
      pulse_reset("reset mid fill");
      chk("mid fill bank_ready nb4", W'(bank_ready_b), 32'd0);
      chk("mid fill wr_ready nb4", W'(wr_ready_b), 32'd1);

      for (int i = 0; i < 400; i++) begin
         set_in(1'($urandom), AW'($urandom), $urandom, ($urandom % 4) == 0,
                1'($urandom), AW'($urandom), ($urandom % 5) == 0, ($urandom % 40) == 0);
         step("random");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/weight_pingpong_buffer.md
WEIGHT_PINGPONG_BUFFER -- requirements
Module: weight_pingpong_buffer

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 2, number of weight banks (2..4) rotated round-robin.
REQ-002 SHALL have parameter LANES, default 4, weights per word (array dimension).
REQ-003 SHALL have parameter DATA_W, default 8, signed weight width.
REQ-004 SHALL have parameter DEPTH, default 256, words per bank (power of two); ADDR_W = log2(DEPTH), BANK_W = max(1, log2(NUM_BANKS)).
REQ-005 SHALL have ports, with clock and reset first:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- clear  in  1  synchronous; empties all banks.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted this cycle.
- wr_addr  in  ADDR_W  word address within the current fill bank.
- wr_data  in  LANES*DATA_W  weight word.
- wr_last  in  1  final word of a layer; closes the fill bank.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  word address within the current read bank.
- rd_data  out  LANES*DATA_W  registered read word.
- rd_valid  out  1  rd_data valid.
- rd_release  in  1  consumer finished with the read bank.
- bank_ready  out  1  read bank holds a complete layer.
- wr_bank  out  BANK_W  index of the fill bank.
- rd_bank  out  BANK_W  index of the read bank.
- full_count  out  BANK_W+1  number of banks in FULL state.
- overflow_err  out  1  sticky; write dropped.
- underflow_err  out  1  sticky; read or release without a full bank.

Function
REQ-006 Each bank SHALL hold state EMPTY, FILLING or FULL.
REQ-007 wr_ready SHALL be 1 iff bank[wr_bank] is EMPTY or FILLING.
REQ-008 An accepted write (wr_valid & wr_ready) SHALL store wr_data at wr_addr of bank[wr_bank] and move an EMPTY bank to FILLING.
REQ-009 An accepted write with wr_last SHALL move that bank to FULL and advance wr_bank modulo NUM_BANKS on the next edge.
REQ-010 wr_valid with wr_ready=0 SHALL be dropped, with no state change, and SHALL set overflow_err.
REQ-011 bank_ready SHALL be 1 iff bank[rd_bank] is FULL.
REQ-012 rd_en with bank_ready=1 SHALL produce rd_data = bank[rd_bank][rd_addr] with rd_valid=1 exactly one cycle later; rd_en=0 gives rd_valid=0 next cycle, and rd_data holds its last value.
REQ-013 rd_en or rd_release with bank_ready=0 SHALL be ignored, give rd_valid=0, and set underflow_err.
REQ-014 rd_release with bank_ready=1 SHALL move bank[rd_bank] to EMPTY and advance rd_bank modulo NUM_BANKS.
REQ-015 rd_en and rd_release in the same cycle SHALL complete the read (data next cycle) and also release the bank.
REQ-016 A write-bank transition and a read-bank transition in the same cycle SHALL both take effect; full_count SHALL reflect the net change (+1-1 = 0).
REQ-017 A bank SHALL become readable on the cycle after its wr_last is accepted; there is no same-cycle write-to-read bypass.
REQ-018 clear SHALL take priority over all other inputs: all banks go EMPTY, pointers go to 0, rd_valid goes to 0; error flags are kept.
REQ-019 Bank contents SHALL NOT be altered by rd_release or clear; only state is affected.

Reset
REQ-020 On reset assertion, independent of clk:
- all banks EMPTY, wr_bank=0, rd_bank=0;
- rd_valid=0, rd_data=0, full_count=0;
- overflow_err=0, underflow_err=0.
Consequently wr_ready=1 and bank_ready=0.
REQ-021 Reset asserted mid-fill or mid-read SHALL abandon the operation; storage contents are undefined-but-unchanged.

Structure
REQ-022 A shared package SHALL hold the bank_state_t enum (EMPTY, FILLING, FULL) and the default values of NUM_BANKS, LANES, DATA_W and DEPTH.
REQ-023 Storage SHALL be one sub-module, weight_bank_sram (1R1W, synchronous write, registered one-cycle read, no reset on the array), instantiated NUM_BANKS times via generate.
REQ-024 The output read mux SHALL select using a registered copy of rd_bank.

Verification
REQ-025 Reset, then fill bank0 with addr 0..3 = 0x01020304.. and wr_last on addr 3 -> bank_ready=1, wr_bank=1, full_count=1; rd_en addr 2 -> rd_valid=1 next cycle with bank0 word 2.
REQ-026 NUM_BANKS=2: fill bank0 and bank1 fully, then wr_valid -> wr_ready=0, write dropped, overflow_err=1; rd_release -> wr_ready=1 next cycle.
REQ-027 From reset, rd_en=1 -> rd_valid=0 next cycle, underflow_err=1, rd_bank still 0.
REQ-028 Same cycle: wr_last into bank1 and rd_release of bank0 -> full_count stays 1, rd_bank=1, wr_bank=0, bank_ready=1.
REQ-029 Same cycle: rd_en addr 5 and rd_release -> rd_data = old bank word 5 next cycle; bank returns to EMPTY.
REQ-030 NUM_BANKS=4: fill 4 layers and release 4 times -> wr_bank and rd_bank both wrap 3->0; assert reset mid-fill -> all outputs return to REQ-020 values asynchronously.
